// File: rtl/up_axi_pkg.sv
// up_axi_pkg: shared AXI response codes, FSM state encodings and timeout read value for up_axi_master
// UP_AXI_MASTER_TIMEOUT_EN adds the DRAIN state to both path encodings.
package up_axi_pkg;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
  localparam logic [31:0] TIMEOUT_RDATA = 32'hdeaddead;
  typedef enum logic [1:0] {
    W_IDLE,
    W_REQ,
    W_RESP
`ifdef UP_AXI_MASTER_TIMEOUT_EN
    , W_DRAIN
`endif
  } w_state_e;
  typedef enum logic [1:0] {
    R_IDLE,
    R_ADDR,
    R_DATA
`ifdef UP_AXI_MASTER_TIMEOUT_EN
    , R_DRAIN
`endif
  } r_state_e;
endpackage

// File: rtl/up_axi_master_timer.sv
// up_axi_master_timer: per-path access timer, one-cycle expired pulse after TIMEOUT_CYCLES run cycles
// Ports: up_clk/up_rstn clock and async active-low reset; clear zeroes the count; run counts;
// expired is high in the run cycle where the count reaches TIMEOUT_CYCLES.
module up_axi_master_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic up_clk,
  input  logic up_rstn,
  input  logic clear,
  input  logic run,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  assign expired = run && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  always_comb cnt_d = clear ? '0 : (run && !expired) ? cnt_q + CW'(1) : cnt_q;
  always_ff @(posedge up_clk or negedge up_rstn)
    if (!up_rstn) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/up_axi_master.sv
// up_axi_master: up_* register bus to AXI4-Lite master bridge, independent read and write paths
// Ports: up_clk/up_rstn clock and async active-low reset; up_wreq/up_waddr/up_wdata -> up_wack/up_werr;
// up_rreq/up_raddr -> up_rack/up_rerr/up_rdata; m_axi_* AXI4-Lite master (AW, W, B, AR, R).
// UP_AXI_MASTER_TIMEOUT_EN: per-path timeout with error ack and a DRAIN state that absorbs the late response.
module up_axi_master
  import up_axi_pkg::*;
#(
  parameter int AXI_ADDRESS_WIDTH = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                         up_clk,
  input  logic                         up_rstn,
  input  logic                         up_wreq,
  input  logic [AXI_ADDRESS_WIDTH-3:0] up_waddr,
  input  logic [31:0]                  up_wdata,
  output logic                         up_wack,
  output logic                         up_werr,
  input  logic                         up_rreq,
  input  logic [AXI_ADDRESS_WIDTH-3:0] up_raddr,
  output logic [31:0]                  up_rdata,
  output logic                         up_rack,
  output logic                         up_rerr,
  output logic                         m_axi_awvalid,
  input  logic                         m_axi_awready,
  output logic [AXI_ADDRESS_WIDTH-1:0] m_axi_awaddr,
  output logic [2:0]                   m_axi_awprot,
  output logic                         m_axi_wvalid,
  input  logic                         m_axi_wready,
  output logic [31:0]                  m_axi_wdata,
  output logic [3:0]                   m_axi_wstrb,
  input  logic                         m_axi_bvalid,
  output logic                         m_axi_bready,
  input  logic [1:0]                   m_axi_bresp,
  output logic                         m_axi_arvalid,
  input  logic                         m_axi_arready,
  output logic [AXI_ADDRESS_WIDTH-1:0] m_axi_araddr,
  output logic [2:0]                   m_axi_arprot,
  input  logic                         m_axi_rvalid,
  output logic                         m_axi_rready,
  input  logic [31:0]                  m_axi_rdata,
  input  logic [1:0]                   m_axi_rresp
);
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end
  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;
  logic awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic [AXI_ADDRESS_WIDTH-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic wack_q, wack_d, werr_q, werr_d;
  logic arvalid_q, arvalid_d, rready_q, rready_d;
  logic rack_q, rack_d, rerr_q, rerr_d;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = 4'hf;
  assign m_axi_bready  = bready_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_rready  = rready_q;
  assign up_wack  = wack_q;
  assign up_werr  = werr_q;
  assign up_rack  = rack_q;
  assign up_rerr  = rerr_q;
  assign up_rdata = rdata_q;
`ifdef UP_AXI_MASTER_TIMEOUT_EN
  logic w_expired, r_expired;
  up_axi_master_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_w_timer (
    .up_clk(up_clk), .up_rstn(up_rstn), .clear(w_state_q == W_IDLE),
    .run(w_state_q == W_REQ || w_state_q == W_RESP), .expired(w_expired)
  );
  up_axi_master_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_r_timer (
    .up_clk(up_clk), .up_rstn(up_rstn), .clear(r_state_q == R_IDLE),
    .run(r_state_q == R_ADDR || r_state_q == R_DATA), .expired(r_expired)
  );
`endif
  always_comb begin
    w_state_d = w_state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wack_d    = 1'b0;
    werr_d    = 1'b0;
    case (w_state_q)
      W_IDLE: if (up_wreq) begin
        awaddr_d  = {up_waddr, 2'b00};
        wdata_d   = up_wdata;
        awvalid_d = 1'b1;
        wvalid_d  = 1'b1;
        w_state_d = W_REQ;
      end
      W_REQ: begin
        awvalid_d = awvalid_q & ~m_axi_awready;
        wvalid_d  = wvalid_q & ~m_axi_wready;
        if (!awvalid_d && !wvalid_d) begin
          bready_d  = 1'b1;
          w_state_d = W_RESP;
        end
`ifdef UP_AXI_MASTER_TIMEOUT_EN
        if (w_expired) begin
          wack_d    = 1'b1;
          werr_d    = 1'b1;
          bready_d  = 1'b1;
          w_state_d = W_DRAIN;
        end
`endif
      end
      W_RESP: if (m_axi_bvalid && bready_q) begin
        wack_d    = 1'b1;
        werr_d    = m_axi_bresp != AXI_RESP_OKAY;
        bready_d  = 1'b0;
        w_state_d = W_IDLE;
      end
`ifdef UP_AXI_MASTER_TIMEOUT_EN
      else if (w_expired) begin
        wack_d    = 1'b1;
        werr_d    = 1'b1;
        w_state_d = W_DRAIN;
      end
      W_DRAIN: begin
        awvalid_d = awvalid_q & ~m_axi_awready;
        wvalid_d  = wvalid_q & ~m_axi_wready;
        if (m_axi_bvalid && bready_q) begin
          bready_d  = 1'b0;
          w_state_d = W_IDLE;
        end
      end
`endif
      default: w_state_d = W_IDLE;
    endcase
  end
  always_comb begin
    r_state_d = r_state_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    araddr_d  = araddr_q;
    rack_d    = 1'b0;
    rerr_d    = 1'b0;
    rdata_d   = '0;
    case (r_state_q)
      R_IDLE: if (up_rreq) begin
        araddr_d  = {up_raddr, 2'b00};
        arvalid_d = 1'b1;
        r_state_d = R_ADDR;
      end
      R_ADDR: begin
        arvalid_d = arvalid_q & ~m_axi_arready;
        if (!arvalid_d) begin
          rready_d  = 1'b1;
          r_state_d = R_DATA;
        end
`ifdef UP_AXI_MASTER_TIMEOUT_EN
        if (r_expired) begin
          rack_d    = 1'b1;
          rerr_d    = 1'b1;
          rdata_d   = TIMEOUT_RDATA;
          rready_d  = 1'b1;
          r_state_d = R_DRAIN;
        end
`endif
      end
      R_DATA: if (m_axi_rvalid && rready_q) begin
        rack_d    = 1'b1;
        rerr_d    = m_axi_rresp != AXI_RESP_OKAY;
        rdata_d   = m_axi_rdata;
        rready_d  = 1'b0;
        r_state_d = R_IDLE;
      end
`ifdef UP_AXI_MASTER_TIMEOUT_EN
      else if (r_expired) begin
        rack_d    = 1'b1;
        rerr_d    = 1'b1;
        rdata_d   = TIMEOUT_RDATA;
        r_state_d = R_DRAIN;
      end
      R_DRAIN: begin
        arvalid_d = arvalid_q & ~m_axi_arready;
        if (m_axi_rvalid && rready_q) begin
          rready_d  = 1'b0;
          r_state_d = R_IDLE;
        end
      end
`endif
      default: r_state_d = R_IDLE;
    endcase
  end
  always_ff @(posedge up_clk or negedge up_rstn)
    if (!up_rstn) begin
      w_state_q <= W_IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wack_q    <= 1'b0;
      werr_q    <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wack_q    <= wack_d;
      werr_q    <= werr_d;
    end
  always_ff @(posedge up_clk or negedge up_rstn)
    if (!up_rstn) begin
      r_state_q <= R_IDLE;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      araddr_q  <= '0;
      rack_q    <= 1'b0;
      rerr_q    <= 1'b0;
      rdata_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      araddr_q  <= araddr_d;
      rack_q    <= rack_d;
      rerr_q    <= rerr_d;
      rdata_q   <= rdata_d;
    end
endmodule

// File: tb/tb_up_axi_master.sv
// tb_up_axi_master: directed self-checking bench for up_axi_master
module tb_up_axi_master;
  logic clk = 1'b0;
  logic up_rstn = 1'b0;
  logic up_wreq = 1'b0, up_rreq = 1'b0;
  logic [13:0] up_waddr = '0, up_raddr = '0;
  logic [31:0] up_wdata = '0;
  logic up_wack, up_werr, up_rack, up_rerr;
  logic [31:0] up_rdata;
  logic awvalid, awready = 1'b0, wvalid, wready = 1'b0, bvalid = 1'b0, bready;
  logic arvalid, arready = 1'b0, rvalid = 1'b0, rready;
  logic [15:0] awaddr, araddr;
  logic [2:0] awprot, arprot;
  logic [31:0] wdata, rdata = '0;
  logic [3:0] wstrb;
  logic [1:0] bresp = 2'b00, rresp = 2'b00;
  int checks = 0, fails = 0;
  int aw_hs = 0, wack_cnt = 0, rack_cnt = 0;
  up_axi_master #(.AXI_ADDRESS_WIDTH(16), .TIMEOUT_CYCLES(16)) dut (
    .up_clk(clk), .up_rstn(up_rstn),
    .up_wreq(up_wreq), .up_waddr(up_waddr), .up_wdata(up_wdata), .up_wack(up_wack), .up_werr(up_werr),
    .up_rreq(up_rreq), .up_raddr(up_raddr), .up_rdata(up_rdata), .up_rack(up_rack), .up_rerr(up_rerr),
    .m_axi_awvalid(awvalid), .m_axi_awready(awready), .m_axi_awaddr(awaddr), .m_axi_awprot(awprot),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
    .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_bresp(bresp),
    .m_axi_arvalid(arvalid), .m_axi_arready(arready), .m_axi_araddr(araddr), .m_axi_arprot(arprot),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready), .m_axi_rdata(rdata), .m_axi_rresp(rresp)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (awvalid && awready) aw_hs++;
    if (up_wack) wack_cnt++;
    if (up_rack) rack_cnt++;
  end
  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    cyc(2);
    checks++; if ({awvalid, wvalid, bready, arvalid, rready} !== 5'b0) begin fails++; $display("FAIL reset_valids got=%b exp=00000", {awvalid, wvalid, bready, arvalid, rready}); end
    checks++; if ({up_wack, up_werr, up_rack, up_rerr, up_rdata} !== 36'h0) begin fails++; $display("FAIL reset_up got=%h exp=0", {up_wack, up_werr, up_rack, up_rerr, up_rdata}); end
    checks++; if ({awaddr, araddr, wdata} !== 64'h0) begin fails++; $display("FAIL reset_addr_data got=%h exp=0", {awaddr, araddr, wdata}); end
    up_rstn = 1'b1;
    cyc(2);
    checks++; if ({awvalid, wvalid, arvalid, up_wack, up_rack} !== 5'b0) begin fails++; $display("FAIL post_reset_idle got=%b exp=00000", {awvalid, wvalid, arvalid, up_wack, up_rack}); end
  endtask
  task automatic test_write_basic;
    int w0;
    w0 = wack_cnt;
    up_wreq = 1'b1; up_waddr = 14'h010; up_wdata = 32'h12345678;
    cyc; up_wreq = 1'b0;
    checks++; if ({awvalid, wvalid, bready} !== 3'b110) begin fails++; $display("FAIL wr1_valids got=%b exp=110", {awvalid, wvalid, bready}); end
    checks++; if (awaddr !== 16'h0040) begin fails++; $display("FAIL wr1_awaddr got=%h exp=0040", awaddr); end
    checks++; if ({wstrb, awprot} !== 7'b1111_000) begin fails++; $display("FAIL wr1_wstrb_prot got=%b exp=1111000", {wstrb, awprot}); end
    checks++; if (wdata !== 32'h12345678) begin fails++; $display("FAIL wr1_wdata got=%h exp=12345678", wdata); end
    awready = 1'b1; wready = 1'b1;
    cyc; awready = 1'b0; wready = 1'b0;
    checks++; if ({awvalid, wvalid, bready} !== 3'b001) begin fails++; $display("FAIL wr1_resp_phase got=%b exp=001", {awvalid, wvalid, bready}); end
    bvalid = 1'b1; bresp = 2'b00;
    cyc; bvalid = 1'b0;
    checks++; if ({up_wack, up_werr, bready} !== 3'b100) begin fails++; $display("FAIL wr1_ack got=%b exp=100", {up_wack, up_werr, bready}); end
    cyc(3);
    checks++; if (wack_cnt - w0 !== 1) begin fails++; $display("FAIL wr1_ack_count got=%0d exp=1", wack_cnt - w0); end
  endtask
  task automatic test_write_order_err;
    up_wreq = 1'b1; up_waddr = 14'h020; up_wdata = 32'h0badf00d;
    cyc; up_wreq = 1'b0;
    wready = 1'b1;
    cyc; wready = 1'b0;
    checks++; if ({awvalid, wvalid} !== 2'b10) begin fails++; $display("FAIL wr2_w_first got=%b exp=10", {awvalid, wvalid}); end
    cyc(4);
    checks++; if ({awvalid, wvalid, bready} !== 3'b100 || awaddr !== 16'h0080) begin fails++; $display("FAIL wr2_aw_held got=%b/%h exp=100/0080", {awvalid, wvalid, bready}, awaddr); end
    awready = 1'b1;
    cyc; awready = 1'b0;
    checks++; if ({awvalid, bready} !== 2'b01) begin fails++; $display("FAIL wr2_aw_done got=%b exp=01", {awvalid, bready}); end
    bvalid = 1'b1; bresp = up_axi_pkg::AXI_RESP_SLVERR;
    cyc; bvalid = 1'b0; bresp = 2'b00;
    checks++; if ({up_wack, up_werr} !== 2'b11) begin fails++; $display("FAIL wr2_slverr got=%b exp=11", {up_wack, up_werr}); end
  endtask
  task automatic test_read;
    up_rreq = 1'b1; up_raddr = 14'h002;
    cyc; up_rreq = 1'b0;
    checks++; if ({arvalid, rready} !== 2'b10 || araddr !== 16'h0008 || arprot !== 3'b000) begin fails++; $display("FAIL rd_addr got=%b/%h/%b exp=10/0008/000", {arvalid, rready}, araddr, arprot); end
    arready = 1'b1;
    cyc; arready = 1'b0;
    checks++; if ({arvalid, rready} !== 2'b01) begin fails++; $display("FAIL rd_data_phase got=%b exp=01", {arvalid, rready}); end
    rdata = 32'hcafef00d;
    cyc(2);
    checks++; if (up_rack !== 1'b0 || up_rdata !== 32'h0) begin fails++; $display("FAIL rd_early got=%b/%h exp=0/00000000", up_rack, up_rdata); end
    rvalid = 1'b1;
    cyc; rvalid = 1'b0;
    checks++; if ({up_rack, up_rerr} !== 2'b10 || up_rdata !== 32'hcafef00d) begin fails++; $display("FAIL rd_ack got=%b/%h exp=10/cafef00d", {up_rack, up_rerr}, up_rdata); end
    cyc;
    checks++; if (up_rack !== 1'b0 || up_rdata !== 32'h0 || rready !== 1'b0) begin fails++; $display("FAIL rd_after got=%b/%h/%b exp=0/00000000/0", up_rack, up_rdata, rready); end
  endtask
  task automatic test_concurrent;
    int a0, w0, r0;
    a0 = aw_hs; w0 = wack_cnt; r0 = rack_cnt;
    up_wreq = 1'b1; up_waddr = 14'h011; up_wdata = 32'h00000011;
    up_rreq = 1'b1; up_raddr = 14'h003;
    cyc; up_rreq = 1'b0; up_waddr = 14'h0aa; up_wdata = 32'h000000aa;
    cyc; up_wreq = 1'b0;
    checks++; if (awaddr !== 16'h0044 || wdata !== 32'h11 || araddr !== 16'h000c) begin fails++; $display("FAIL cc_addrs got=%h/%h/%h exp=0044/00000011/000c", awaddr, wdata, araddr); end
    awready = 1'b1; wready = 1'b1; arready = 1'b1;
    cyc; awready = 1'b0; wready = 1'b0; arready = 1'b0;
    bvalid = 1'b1; rvalid = 1'b1; rdata = 32'h5a5a0001;
    cyc; bvalid = 1'b0; rvalid = 1'b0;
    checks++; if ({up_wack, up_werr, up_rack, up_rerr} !== 4'b1010 || up_rdata !== 32'h5a5a0001) begin fails++; $display("FAIL cc_acks got=%b/%h exp=1010/5a5a0001", {up_wack, up_werr, up_rack, up_rerr}, up_rdata); end
    cyc(5);
    checks++; if (aw_hs - a0 !== 1 || awvalid !== 1'b0) begin fails++; $display("FAIL cc_aw_handshakes got=%0d/%b exp=1/0", aw_hs - a0, awvalid); end
    checks++; if (wack_cnt - w0 !== 1 || rack_cnt - r0 !== 1) begin fails++; $display("FAIL cc_ack_counts got=%0d/%0d exp=1/1", wack_cnt - w0, rack_cnt - r0); end
  endtask
  task automatic test_reset_mid;
    int w0;
    w0 = wack_cnt;
    up_wreq = 1'b1; up_waddr = 14'h033; up_wdata = 32'h33333333;
    cyc; up_wreq = 1'b0;
    awready = 1'b1; wready = 1'b1;
    cyc; awready = 1'b0; wready = 1'b0;
    checks++; if (bready !== 1'b1) begin fails++; $display("FAIL rm_in_resp got=%b exp=1", bready); end
    #2 up_rstn = 1'b0;
    #1;
    checks++; if ({awvalid, wvalid, bready, arvalid, rready, up_wack, up_rack} !== 7'b0 || {awaddr, wdata} !== 48'h0) begin fails++; $display("FAIL rm_async_clear got=%b/%h exp=0/0", {awvalid, wvalid, bready, arvalid, rready, up_wack, up_rack}, {awaddr, wdata}); end
    bvalid = 1'b1;
    cyc; bvalid = 1'b0;
    up_rstn = 1'b1;
    cyc(3);
    checks++; if (wack_cnt - w0 !== 0) begin fails++; $display("FAIL rm_no_ack got=%0d exp=0", wack_cnt - w0); end
    up_wreq = 1'b1; up_waddr = 14'h044; up_wdata = 32'h44444444;
    cyc; up_wreq = 1'b0;
    checks++; if ({awvalid, wvalid} !== 2'b11 || awaddr !== 16'h0110) begin fails++; $display("FAIL rm_next_req got=%b/%h exp=11/0110", {awvalid, wvalid}, awaddr); end
    awready = 1'b1; wready = 1'b1;
    cyc; awready = 1'b0; wready = 1'b0;
    bvalid = 1'b1;
    cyc; bvalid = 1'b0;
    checks++; if ({up_wack, up_werr} !== 2'b10) begin fails++; $display("FAIL rm_next_ack got=%b exp=10", {up_wack, up_werr}); end
  endtask
`ifdef UP_AXI_MASTER_TIMEOUT_EN
  task automatic test_timeout;
    int n, r0;
    n = 0;
    up_rreq = 1'b1; up_raddr = 14'h005;
    cyc; up_rreq = 1'b0;
    r0 = rack_cnt;
    while (!up_rack && n < 40) begin cyc; n++; end
    checks++; if (n !== 16) begin fails++; $display("FAIL to_latency got=%0d exp=16", n); end
    checks++; if ({up_rack, up_rerr} !== 2'b11 || up_rdata !== 32'hdeaddead) begin fails++; $display("FAIL to_ack got=%b/%h exp=11/deaddead", {up_rack, up_rerr}, up_rdata); end
    checks++; if ({arvalid, rready} !== 2'b11) begin fails++; $display("FAIL to_drain_hold got=%b exp=11", {arvalid, rready}); end
    up_rreq = 1'b1; up_raddr = 14'h006;
    cyc; up_rreq = 1'b0;
    checks++; if (araddr !== 16'h0014 || arvalid !== 1'b1) begin fails++; $display("FAIL to_drop got=%h/%b exp=0014/1", araddr, arvalid); end
    arready = 1'b1;
    cyc; arready = 1'b0;
    rvalid = 1'b1; rdata = 32'h00000011;
    cyc; rvalid = 1'b0;
    checks++; if (up_rack !== 1'b0 || rready !== 1'b0) begin fails++; $display("FAIL to_absorb got=%b/%b exp=0/0", up_rack, rready); end
    cyc;
    checks++; if (rack_cnt - r0 !== 1) begin fails++; $display("FAIL to_ack_count got=%0d exp=1", rack_cnt - r0); end
    up_rreq = 1'b1; up_raddr = 14'h004;
    cyc; up_rreq = 1'b0;
    arready = 1'b1;
    cyc; arready = 1'b0;
    rvalid = 1'b1; rdata = 32'h600d600d;
    cyc; rvalid = 1'b0;
    checks++; if ({up_rack, up_rerr} !== 2'b10 || up_rdata !== 32'h600d600d) begin fails++; $display("FAIL to_next_read got=%b/%h exp=10/600d600d", {up_rack, up_rerr}, up_rdata); end
  endtask
`endif
  initial begin
    test_reset;
    test_write_basic;
    test_write_order_err;
    test_read;
    test_concurrent;
    test_reset_mid;
`ifdef UP_AXI_MASTER_TIMEOUT_EN
    test_timeout;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
